// File: rtl/cortez_pkg.sv
// cortez_pkg
// Shared definitions for the neuron datapath blocks.
//   loader_state_e : FILL/FIRE state encoding of the serial-to-parallel loader
//   idx_width()    : width of an index counter able to address n slots
package cortez_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FIRE = 1'b1
    } loader_state_e;

    // A single-slot vector still needs a one-bit counter so the index
    // register never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_input_loader.sv
// neuron_input_loader
// Collects a serial stream of signed fixed-point values into a parallel
// vector for a neuron. A frame is NUM_INPUTS values, the last one flagged
// with last_in. A complete frame produces a one-cycle valid_out strobe;
// a frame whose last_in arrives early or is missing produces a one-cycle
// error_out strobe instead and the loader realigns to slot 0.
// Values are copied bit-exact; FRAC_BITS only documents the number format.
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   value_in   : serial value (signed, WIDTH bits)
//   valid_in   : value_in is valid
//   last_in    : final element of the frame, qualified by valid_in
//   ready_out  : loader accepts value_in this cycle
//   clear_in   : synchronous frame abort, overrides valid_in
//   values_out : parallel vector, NUM_INPUTS slots of WIDTH bits
//   valid_out  : one-cycle strobe, values_out holds a complete frame
//   error_out  : one-cycle framing-error strobe
module neuron_input_loader
    import cortez_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] value_in,
    input  logic                    valid_in,
    input  logic                    last_in,
    output logic                    ready_out,
    input  logic                    clear_in,
    output logic signed [WIDTH-1:0] values_out [NUM_INPUTS],
    output logic                    valid_out,
    output logic                    error_out
);

    localparam int IDX_W = idx_width(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    // Reject parameter sets that cannot describe a valid frame or format.
    if (NUM_INPUTS < 1 || FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_params
        $error("neuron_input_loader: illegal NUM_INPUTS/FRAC_BITS/WIDTH combination");
    end

    loader_state_e    state;
    logic [IDX_W-1:0] idx;
    logic             armed;
    logic             accept;

    // armed holds ready_out low during reset and until the first clock
    // after release, so the loader never claims a transfer it cannot take.
    assign ready_out = armed && (state == FILL);
    assign accept    = valid_in && ready_out && !clear_in;

    // Single FSM: slot writes, index tracking and the registered strobes.
    // A clear always wins over a pending transfer and never flags an error;
    // in FIRE the strobe is already out, so a clear only forces the return
    // to FILL, which happens anyway.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            idx       <= '0;
            armed     <= 1'b0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                values_out[i] <= '0;
            end
        end else begin
            armed     <= 1'b1;
            valid_out <= 1'b0;
            error_out <= 1'b0;
            case (state)
                FILL: begin
                    if (clear_in) begin
                        idx <= '0;
                    end else if (accept) begin
                        values_out[idx] <= value_in;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (last_in) begin
                                state     <= FIRE;
                                valid_out <= 1'b1;
                            end else begin
                                error_out <= 1'b1;
                            end
                        end else if (last_in) begin
                            idx       <= '0;
                            error_out <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= FILL;
                    idx   <= '0;
                end
                default: begin
                    state <= FILL;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader
// Scoreboard bench for neuron_input_loader (NUM_INPUTS=4, WIDTH=8).
// The driver keeps a frame model: completed frames are queued as expected
// vectors, framing errors are counted. A negedge monitor pops a frame for
// every valid_out strobe and counts error_out strobes.
module tb_neuron_input_loader;

    localparam int NUM_INPUTS = 4;
    localparam int WIDTH      = 8;
    localparam int FRAC_BITS  = 3;

    logic                    clk;
    logic                    rstn;
    logic signed [WIDTH-1:0] value_in;
    logic                    valid_in;
    logic                    last_in;
    logic                    ready_out;
    logic                    clear_in;
    logic signed [WIDTH-1:0] values_out [NUM_INPUTS];
    logic                    valid_out;
    logic                    error_out;

    neuron_input_loader #(
        .NUM_INPUTS (NUM_INPUTS),
        .WIDTH      (WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .value_in   (value_in),
        .valid_in   (valid_in),
        .last_in    (last_in),
        .ready_out  (ready_out),
        .clear_in   (clear_in),
        .values_out (values_out),
        .valid_out  (valid_out),
        .error_out  (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [NUM_INPUTS*WIDTH-1:0] expFrames [$];
    logic [NUM_INPUTS*WIDTH-1:0] modelFrame;
    int                          modelIdx   = 0;
    int                          expErrors  = 0;
    int                          errSeen    = 0;
    int                          cycleCount = 0;
    int                          validCycles [$];
    logic [NUM_INPUTS*WIDTH-1:0] monFrame;
    logic [WIDTH-1:0]            monSlot;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: check each strobe against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            cycleCount++;
            if (error_out) errSeen++;
            if (valid_out) begin
                validCycles.push_back(cycleCount);
                checkOutput("ready_low_in_fire", 64'(ready_out), 64'd0);
                if (expFrames.size() == 0) begin
                    checkOutput("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    monFrame = expFrames.pop_front();
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        monSlot = values_out[i];
                        checkOutput($sformatf("slot%0d", i), 64'(monSlot),
                                    64'(monFrame[i*WIDTH +: WIDTH]));
                    end
                end
            end
        end
    end

    // Drive one element, hold it until the loader is ready, and update the
    // model as of the transfer edge that follows.
    task automatic applyStimulus(input logic [WIDTH-1:0] v, input logic last);
        int waitCycles;
        @(negedge clk);
        value_in  = v;
        last_in   = last;
        valid_in  = 1'b1;
        clear_in  = 1'b0;
        waitCycles = 0;
        while (!ready_out && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!ready_out) begin
            checkOutput("ready_timeout", 64'(ready_out), 64'd1);
            return;
        end
        modelFrame[modelIdx*WIDTH +: WIDTH] = v;
        if (modelIdx == NUM_INPUTS - 1 && last) begin
            expFrames.push_back(modelFrame);
            modelIdx = 0;
        end else if (modelIdx == NUM_INPUTS - 1 || last) begin
            expErrors++;
            modelIdx = 0;
        end else begin
            modelIdx++;
        end
    endtask

    task automatic sendFrame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        applyStimulus(a, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(c, 1'b0);
        applyStimulus(d, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            last_in  = 1'b0;
            clear_in = 1'b0;
        end
    endtask

    // Clear with a valid element offered at the same time; it must be dropped.
    task automatic clearPulse();
        @(negedge clk);
        clear_in = 1'b1;
        valid_in = 1'b1;
        last_in  = 1'b0;
        value_in = 8'h7F;
        modelIdx = 0;
        @(negedge clk);
        clear_in = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 64'(valid_out), 64'd0);
        checkOutput({tag, "_error"}, 64'(error_out), 64'd0);
        checkOutput({tag, "_ready"}, 64'(ready_out), 64'd0);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            monSlot = values_out[i];
            checkOutput($sformatf("%s_slot%0d", tag, i), 64'(monSlot), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rstn       = 1'b0;
        value_in   = '0;
        valid_in   = 1'b0;
        last_in    = 1'b0;
        clear_in   = 1'b0;
        modelFrame = '0;

        // Power-on reset and release
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", 64'(ready_out), 64'd1);

        // Basic frame; valid_out one cycle after the last transfer
        sendFrame(8'h08, 8'h10, 8'hF8, 8'h04);
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
        checkOutput("latency_valid", 64'(valid_out), 64'd1);
        @(negedge clk);
        checkOutput("valid_one_cycle", 64'(valid_out), 64'd0);
        idle(2);

        // Back-to-back frames with valid_in held high
        validCycles.delete();
        sendFrame(8'h7F, 8'h80, 8'h01, 8'hFF);
        sendFrame(8'h55, 8'hAA, 8'h33, 8'hCC);
        idle(3);
        checkOutput("b2b_count", 64'(validCycles.size()), 64'd2);
        if (validCycles.size() == 2)
            checkOutput("b2b_gap", 64'(validCycles[1] - validCycles[0]), 64'd5);

        // Early last_in on the second element, then a clean frame
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b1);
        idle(2);
        checkOutput("early_last_err", 64'(errSeen), 64'(expErrors));
        sendFrame(8'h21, 8'h22, 8'h23, 8'h24);
        idle(2);

        // Missing last_in, then a clean frame on realigned slots
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h34, 1'b0);
        idle(2);
        checkOutput("missing_last_err", 64'(errSeen), 64'(expErrors));
        sendFrame(8'h41, 8'h42, 8'h43, 8'h44);
        idle(2);

        // Clear after three elements, then a full frame
        applyStimulus(8'h51, 1'b0);
        applyStimulus(8'h52, 1'b0);
        applyStimulus(8'h53, 1'b0);
        clearPulse();
        sendFrame(8'h61, 8'h62, 8'h63, 8'h64);
        idle(2);
        checkOutput("clear_no_err", 64'(errSeen), 64'(expErrors));

        // Clear during FIRE keeps the strobe already out
        sendFrame(8'h71, 8'h72, 8'h73, 8'h74);
        clearPulse();
        sendFrame(8'h81, 8'h82, 8'h83, 8'h84);
        idle(2);

        // Reset mid-frame discards the partial frame
        applyStimulus(8'h91, 1'b0);
        applyStimulus(8'h92, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rstn     = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        modelIdx = 0;
        @(negedge clk);
        checkOutput("ready_after_mid_reset", 64'(ready_out), 64'd1);
        sendFrame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        idle(3);

        checkOutput("frames_pending", 64'(expFrames.size()), 64'd0);
        checkOutput("error_count", 64'(errSeen), 64'(expErrors));
        checkOutput("expected_errors", 64'(expErrors), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/neuron_input_loader.md
NEURON_INPUT_LOADER -- requirements
Module: NEURON_INPUT_LOADER

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of values packed per frame, legal range >= 1.
REQ-002 SHALL have parameter WIDTH, default 8: fixed-point value width.
REQ-003 SHALL have parameter FRAC_BITS, default 3: fractional bits, carried through untouched.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port VALUE_IN  input  WIDTH (signed)  serial input value.
REQ-007 SHALL have port VALID_IN  input  1  VALUE_IN is valid.
REQ-008 SHALL have port LAST_IN  input  1  marks the final element of a frame; qualified by VALID_IN.
REQ-009 SHALL have port READY_OUT  output  1  loader accepts VALUE_IN this cycle.
REQ-010 SHALL have port CLEAR_IN  input  1  synchronous frame abort.
REQ-011 SHALL have port VALUES_OUT  output  WIDTH (signed) x NUM_INPUTS unpacked array  parallel vector for the neuron VALUES_IN.
REQ-012 SHALL have port VALID_OUT  output  1  one-cycle strobe; VALUES_OUT is complete.
REQ-013 SHALL have port ERROR_OUT  output  1  one-cycle framing-error strobe.

Function
REQ-014 SHALL implement a two-state FSM: FILL and FIRE.
REQ-015 In FILL, READY_OUT SHALL be 1; a transfer occurs when VALID_IN and READY_OUT are both 1.
REQ-016 On each transfer, VALUE_IN SHALL be written to VALUES_OUT[idx], and idx SHALL increment.
REQ-017 A transfer with idx == NUM_INPUTS-1 and LAST_IN == 1 SHALL reset idx to 0 and move to FIRE.
REQ-018 In FIRE, READY_OUT SHALL be 0 and VALID_OUT SHALL be 1 for exactly one cycle; the next state SHALL be FILL.
REQ-019 Latency: VALID_OUT SHALL rise the cycle after the last-element transfer; throughput is one frame per NUM_INPUTS+1 cycles.
REQ-020 VALUES_OUT SHALL be stable during the FIRE cycle; slots SHALL otherwise change only on transfers to them.
REQ-021 Early LAST_IN (LAST_IN == 1 with idx < NUM_INPUTS-1) SHALL store the value, pulse ERROR_OUT the next cycle, reset idx to 0, stay in FILL, and produce no VALID_OUT.
REQ-022 Missing LAST_IN (idx == NUM_INPUTS-1 and LAST_IN == 0) SHALL store the value, pulse ERROR_OUT the next cycle, reset idx to 0, stay in FILL, and produce no VALID_OUT.
REQ-023 CLEAR_IN SHALL have priority over VALID_IN: no transfer, idx goes to 0, next state is FILL, no ERROR_OUT.
REQ-024 CLEAR_IN during FIRE SHALL NOT suppress the VALID_OUT already asserted that cycle.
REQ-025 With NUM_INPUTS == 1, every transfer with LAST_IN == 1 SHALL fire.
REQ-026 The idx counter width SHALL be max(1, $clog2(NUM_INPUTS)) bits; idx SHALL never exceed NUM_INPUTS-1.
REQ-027 No arithmetic SHALL be performed on values: bit-exact pass-through.

Reset
REQ-028 While RSTN == 0: state SHALL be FILL, idx 0, VALID_OUT 0, ERROR_OUT 0, all VALUES_OUT slots 0.
REQ-029 READY_OUT SHALL be 0 while RSTN == 0 and 1 from the first clock after release.
REQ-030 Reset mid-frame SHALL discard the partial frame with no VALID_OUT or ERROR_OUT.

Structure
REQ-031 The FSM state enum (FILL, FIRE) SHALL reside in the shared package CORTEZ_PKG.
REQ-032 No sub-module SHALL be instantiated; the block is a single FSM, counter and register array.
REQ-033 All outputs SHALL be registered except READY_OUT, which decodes the state.

Verification
REQ-034 NUM_INPUTS=4, stream 0x08,0x10,0xF8,0x04 with LAST_IN on the 4th -> VALID_OUT 1 cycle later with VALUES_OUT = {0x08,0x10,0xF8,0x04}, READY_OUT low that cycle.
REQ-035 Two back-to-back frames with VALID_IN held high -> VALID_OUT strobes 5 cycles apart and the second vector is correct.
REQ-036 LAST_IN on the 2nd element -> ERROR_OUT pulses and there is no VALID_OUT; a following clean 4-element frame fires correctly.
REQ-037 Four elements without LAST_IN -> ERROR_OUT pulses and there is no VALID_OUT; idx realigns to 0.
REQ-038 CLEAR_IN after 3 elements, then a full frame -> exactly one VALID_OUT with the new data.
REQ-039 RSTN asserted after 2 elements -> all outputs 0 immediately; after release a full frame fires normally.
